// File: rtl/data_memory.sv
// data_memory: DEPTH-byte little-endian RAM with combinational read,
// unaligned word access wrapping modulo DEPTH, async clear on reset.
module data_memory #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic        size,
  input  logic [31:0] write_data,
  input  logic        mem_rd,
  input  logic        mem_wr,
  output logic [31:0] read_data
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] a0;
  logic [AW-1:0] a1;
  logic [AW-1:0] a2;
  logic [AW-1:0] a3;
  logic          unused_addr;

  // AW-bit adds wrap DEPTH-1 back to 0 for free
  assign a0 = address[AW-1:0];
  assign a1 = a0 + AW'(1);
  assign a2 = a0 + AW'(2);
  assign a3 = a0 + AW'(3);

  assign unused_addr = ^address[31:AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (mem_wr) begin
      mem[a0] <= write_data[7:0];
      if (size) begin
        mem[a1] <= write_data[15:8];
        mem[a2] <= write_data[23:16];
        mem[a3] <= write_data[31:24];
      end
    end
  end

  always_comb begin
    read_data = 32'h0;
    if (rst_n && mem_rd) begin
      if (size) begin
        read_data = {mem[a3], mem[a2], mem[a1], mem[a0]};
      end else begin
        read_data = {24'h0, mem[a0]};
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: scoreboard bench for data_memory covering byte/word,
// unaligned, wrap, aliasing, read-disable, rd+wr and async reset.
module tb_data_memory;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] address = '0;
  logic        size = 1'b0;
  logic [31:0] write_data = '0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [31:0] read_data;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] sb [$];
  logic [31:0] exp;
  logic [7:0]  model [DEPTH];

  data_memory #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .address    (address),
    .size       (size),
    .write_data (write_data),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  function automatic int idx(input logic [31:0] a, input int k);
    return int'((a + 32'(k)) % DEPTH);
  endfunction

  function automatic void model_write(input logic [31:0] a,
                                      input logic sz,
                                      input logic [31:0] d);
    model[idx(a, 0)] = d[7:0];
    if (sz) begin
      model[idx(a, 1)] = d[15:8];
      model[idx(a, 2)] = d[23:16];
      model[idx(a, 3)] = d[31:24];
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a,
                                             input logic sz);
    if (sz)
      return {model[idx(a, 3)], model[idx(a, 2)],
              model[idx(a, 1)], model[idx(a, 0)]};
    return {24'h0, model[idx(a, 0)]};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
  endfunction

  task automatic write_op(input logic [31:0] a, input logic sz,
                          input logic [31:0] d);
    @(negedge clk);
    address = a; size = sz; write_data = d;
    mem_wr = 1'b1; mem_rd = 1'b0;
    @(posedge clk);
    #1;
    mem_wr = 1'b0;
    model_write(a, sz, d);
  endtask

  task automatic test_reset();
    logic [31:0] a [3];
    logic        s [3];
    model_clear();
    rst_n = 1'b0;
    a = '{32'd0, 32'd277, 32'd8};
    s = '{1'b0, 1'b1, 1'b1};
    mem_wr = 1'b1; write_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      address = a[i]; size = s[i]; mem_rd = 1'b1;
      sb.push_back(32'h0);
      #1;
      exp = sb.pop_front();
      tests++;
      if (read_data !== exp) begin
        fails++;
        $display("FAIL reset_read[%0d]: got %h expected %h",
                 i, read_data, exp);
      end
    end
    @(negedge clk);
    mem_wr = 1'b0;
    rst_n = 1'b1;
    address = 32'd8; size = 1'b1; mem_rd = 1'b1;
    sb.push_back(32'h0);
    #1;
    exp = sb.pop_front();
    tests++;
    if (read_data !== exp) begin
      fails++;
      $display("FAIL reset_blocks_write: got %h expected %h",
               read_data, exp);
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] a [3];
    logic        s [3];
    logic [31:0] e [3];
    write_op(32'd0, 1'b0, 32'd277);
    a = '{32'd0, 32'd1, 32'd0};
    s = '{1'b0, 1'b0, 1'b1};
    e = '{32'h0000_0015, 32'h0, 32'h0000_0015};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      address = a[i]; size = s[i]; mem_rd = 1'b1;
      sb.push_back(e[i]);
      #1;
      exp = sb.pop_front();
      tests++;
      if (read_data !== exp) begin
        fails++;
        $display("FAIL byte_write[%0d]: got %h expected %h",
                 i, read_data, exp);
      end
    end
  endtask

  task automatic test_word_unaligned();
    logic [31:0] a [5];
    logic        s [5];
    logic [31:0] e [5];
    write_op(32'd277, 1'b1, 32'd277);
    a = '{32'd277, 32'd277, 32'd278, 32'd280, 32'd281};
    s = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    e = '{32'h115, 32'h15, 32'h01, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      address = a[i]; size = s[i]; mem_rd = 1'b1;
      sb.push_back(e[i]);
      #1;
      exp = sb.pop_front();
      tests++;
      if (read_data !== exp) begin
        fails++;
        $display("FAIL unaligned[%0d]: got %h expected %h",
                 i, read_data, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a [5];
    logic        s [5];
    logic [31:0] e [5];
    write_op(32'(DEPTH - 2), 1'b1, 32'hAABB_CCDD);
    a = '{32'(DEPTH - 2), 32'(DEPTH + 1), 32'd0,
          32'(DEPTH - 1), 32'hFFFF_0000 + 32'(DEPTH - 2)};
    s = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    e = '{32'hAABB_CCDD, 32'hAA, 32'hBB, 32'hCC, 32'hAABB_CCDD};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      address = a[i]; size = s[i]; mem_rd = 1'b1;
      sb.push_back(e[i]);
      #1;
      exp = sb.pop_front();
      tests++;
      if (read_data !== exp) begin
        fails++;
        $display("FAIL wrap[%0d]: got %h expected %h",
                 i, read_data, exp);
      end
    end
  endtask

  task automatic test_read_disable();
    @(negedge clk);
    address = 32'(DEPTH - 2); size = 1'b1; mem_rd = 1'b0;
    sb.push_back(32'h0);
    #1;
    exp = sb.pop_front();
    tests++;
    if (read_data !== exp) begin
      fails++;
      $display("FAIL read_disable: got %h expected %h", read_data, exp);
    end
  endtask

  task automatic test_rd_wr_same();
    @(negedge clk);
    address = 32'd0; size = 1'b1; write_data = 32'h1122_3344;
    mem_rd = 1'b1; mem_wr = 1'b1;
    sb.push_back(32'h0000_AABB);
    #1;
    exp = sb.pop_front();
    tests++;
    if (read_data !== exp) begin
      fails++;
      $display("FAIL rdwr_pre: got %h expected %h", read_data, exp);
    end
    @(posedge clk);
    #1;
    mem_wr = 1'b0;
    model_write(32'd0, 1'b1, 32'h1122_3344);
    sb.push_back(32'h1122_3344);
    exp = sb.pop_front();
    tests++;
    if (read_data !== exp) begin
      fails++;
      $display("FAIL rdwr_post: got %h expected %h", read_data, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic        s;
    logic [31:0] d;
    logic        w;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a = ($urandom & ~32'(DEPTH - 1)) |
          32'((DEPTH - 8 + $urandom_range(0, 15)) % DEPTH);
      s = 1'($urandom_range(0, 1));
      d = $urandom;
      w = ($urandom_range(0, 3) != 0);
      address = a; size = s; write_data = d;
      mem_wr = w; mem_rd = 1'b1;
      sb.push_back(model_read(a, s));
      #1;
      exp = sb.pop_front();
      tests++;
      if (read_data !== exp) begin
        fails++;
        $display("FAIL b2b[%0d] a=%h s=%0d: got %h expected %h",
                 i, a, s, read_data, exp);
      end
      @(posedge clk);
      if (w) model_write(a, s, d);
    end
    @(negedge clk);
    mem_wr = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      a = 32'((DEPTH - 8 + k) % DEPTH);
      address = a; size = 1'b1; mem_rd = 1'b1;
      sb.push_back(model_read(a, 1'b1));
      #1;
      exp = sb.pop_front();
      tests++;
      if (read_data !== exp) begin
        fails++;
        $display("FAIL b2b_sweep[%0d]: got %h expected %h",
                 k, read_data, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    address = 32'd277; size = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0;
    sb.push_back(32'h115);
    #1;
    exp = sb.pop_front();
    tests++;
    if (read_data !== exp) begin
      fails++;
      $display("FAIL ares_pre: got %h expected %h", read_data, exp);
    end
    write_data = 32'hFFFF_FFFF; mem_wr = 1'b1;
    #1;
    rst_n = 1'b0;
    model_clear();
    sb.push_back(32'h0);
    #1;
    exp = sb.pop_front();
    tests++;
    if (read_data !== exp) begin
      fails++;
      $display("FAIL ares_immediate: got %h expected %h", read_data, exp);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    mem_wr = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      address = (i == 0) ? 32'd277 : 32'(DEPTH - 2);
      sb.push_back(32'h0);
      #1;
      exp = sb.pop_front();
      tests++;
      if (read_data !== exp) begin
        fails++;
        $display("FAIL ares_cleared[%0d]: got %h expected %h",
                 i, read_data, exp);
      end
    end
    write_op(32'd277, 1'b1, 32'hCAFE_F00D);
    @(negedge clk);
    address = 32'd277; size = 1'b1; mem_rd = 1'b1;
    sb.push_back(32'hCAFE_F00D);
    #1;
    exp = sb.pop_front();
    tests++;
    if (read_data !== exp) begin
      fails++;
      $display("FAIL ares_first_write: got %h expected %h",
               read_data, exp);
    end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_word_unaligned();
    test_wrap();
    test_read_disable();
    test_rd_wr_same();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DEPTH, default 1024, number of byte locations; SHALL be a power of two, minimum 4.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 address  input  32  byte address of the access.
REQ-005 size  input  1  access width: 0 = byte, 1 = word (32-bit).
REQ-006 write_data  input  32  store data; byte access uses bits [7:0] only.
REQ-007 mem_rd  input  1  read enable.
REQ-008 mem_wr  input  1  write enable.
REQ-009 read_data  output  32  load data.

Function
REQ-010 Storage SHALL be DEPTH bytes, byte-addressed, little-endian.
REQ-011 Effective address SHALL be address modulo DEPTH; upper address bits ignored, no error flagged.
REQ-012 No alignment restriction: word access at any byte address SHALL use bytes A, A+1, A+2, A+3, each index taken modulo DEPTH (wrap from DEPTH-1 to 0).
REQ-013 Write SHALL occur on rising clk when mem_wr=1 and rst_n=1.
REQ-014 Byte write (size=0) SHALL store write_data[7:0] at A; no other byte changes.
REQ-015 Word write (size=1) SHALL store write_data[7:0] at A, [15:8] at A+1, [23:16] at A+2, [31:24] at A+3.
REQ-016 Read SHALL be combinational (zero-cycle latency) from address, size, mem_rd and memory contents.
REQ-017 mem_rd=1, size=0: read_data SHALL be {24'h0, mem[A]} (zero-extended).
REQ-018 mem_rd=1, size=1: read_data SHALL be {mem[A+3], mem[A+2], mem[A+1], mem[A]}.
REQ-019 mem_rd=0: read_data SHALL be 32'h0.
REQ-020 mem_rd=1 and mem_wr=1 together: write SHALL occur at the edge; read_data SHALL show pre-edge contents before the edge and new contents after it (no bypass).
REQ-021 Inputs SHALL be don't-care when both enables are low; memory SHALL hold.
REQ-022 No handshake, ready or busy signal; every cycle SHALL accept a new access.

Reset
REQ-023 rst_n=0 SHALL immediately, without a clock edge, clear every byte of memory to 8'h00.
REQ-024 While rst_n=0, writes SHALL be blocked; read_data SHALL be 32'h0 regardless of mem_rd.
REQ-025 Reset asserted mid-operation SHALL abort any pending write; no partial word SHALL be written.
REQ-026 After rst_n deasserts, the first rising clk SHALL accept a write normally.

Verification
REQ-027 Byte write: reset, address=0, size=0, write_data=277 (0x115), mem_wr=1 for one edge -> mem[0]=0x15, mem[1] unchanged (0x00); then mem_rd=1, mem_wr=0 -> read_data=0x00000015.
REQ-028 Word write, unaligned: address=277, size=1, write_data=277, mem_wr=1 for one edge -> bytes 277..280 = 0x15, 0x01, 0x00, 0x00; read with size=1 -> 0x00000115; read with size=0 -> 0x00000015.
REQ-029 Wrap: address=DEPTH-2, size=1, write 0xAABBCCDD -> mem[DEPTH-2]=0xDD, mem[DEPTH-1]=0xCC, mem[0]=0xBB, mem[1]=0xAA; word read at DEPTH-2 -> 0xAABBCCDD; address=DEPTH+1 (aliasing), byte read -> 0x000000AA.
REQ-030 Read disabled: after the writes above, mem_rd=0 -> read_data=0x00000000; mem_rd=1, mem_wr=1 at address 0, write 0x11223344 -> old word before the edge, 0x11223344 after.
REQ-031 Async reset: after writes, pull rst_n low between clock edges -> read_data=0 at once; release, word read at 277 -> 0x00000000; mem_wr=1 held during reset -> no write occurs.
